// File: rtl/io_port_pkg.sv
// Shared types and constants for the host-to-core IO port controller.
package io_port_pkg;

  // Transfer phases, in the order the host walks through them.
  typedef enum logic [2:0] {
    S_CW       = 3'd0,
    S_MAP      = 3'd1,
    S_FC_WAIT  = 3'd2,
    S_FC_LOAD  = 3'd3,
    S_RES_WAIT = 3'd4,
    S_RES_OUT  = 3'd5
  } state_t;

  // Core buffer selector encodings carried on wr_sel.
  localparam logic [1:0] SEL_CONV = 2'd0;
  localparam logic [1:0] SEL_MAP  = 2'd1;
  localparam logic [1:0] SEL_FC   = 2'd2;

  // Default word counts for each phase.
  localparam int DEF_N_CONV_W   = 6;
  localparam int DEF_N_MAP      = 136;
  localparam int DEF_N_FC_GRP   = 10;
  localparam int DEF_FC_GRP_LEN = 6;

  // Host bus split: upper bits on the input port, low nibble on the shared pad.
  localparam int HOST_W = 12;
  localparam int PAD_W  = 4;

endpackage

// File: rtl/io_port_ctrl_if.sv
// Host-side bundle of the IO port: word stream in, result out on the shared pad.
//
// Handshake: a word transfers on a rising clk edge where in_valid_port and
// in_ready_port are both 1. The host may hold in_valid_port high while
// in_ready_port is 0; nothing transfers in those cycles. When out_en_port is 1
// the block drives the pad and the host must release it.
interface io_port_ctrl_if;
  import io_port_pkg::*;

  logic              mode_port;
  logic              in_valid_port;
  logic [HOST_W-1:0] data_in_port;
  logic [PAD_W-1:0]  data_inout_i;
  logic [PAD_W-1:0]  data_inout_o;
  logic              data_inout_oe;
  logic              in_ready_port;
  logic              out_en_port;

  // Host side drives words and watches ready / result.
  modport master (
    output mode_port, in_valid_port, data_in_port, data_inout_i,
    input  data_inout_o, data_inout_oe, in_ready_port, out_en_port
  );

  // Controller side.
  modport slave (
    input  mode_port, in_valid_port, data_in_port, data_inout_i,
    output data_inout_o, data_inout_oe, in_ready_port, out_en_port
  );

endinterface

// File: rtl/io_port_ctrl.sv
// IO port controller: streams conv weights, map words and grouped FC weights
// from the host into the core buffers, then presents the core's class label
// on the shared pad until the next reset.
//
// Handshake: a word is accepted on a rising clk edge where in_valid_port and
// in_ready_port are both 1; in_ready_port is registered, so it changes only
// on the edge that moves the FSM into or out of a loading phase.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int N_CONV_W   = DEF_N_CONV_W,
  parameter int N_MAP      = DEF_N_MAP,
  parameter int N_FC_GRP   = DEF_N_FC_GRP,
  parameter int FC_GRP_LEN = DEF_FC_GRP_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_port,
  input  logic              in_valid_port,
  input  logic [HOST_W-1:0] data_in_port,
  input  logic [PAD_W-1:0]  data_inout_i,
  output logic [PAD_W-1:0]  data_inout_o,
  output logic              data_inout_oe,
  output logic              in_ready_port,
  output logic              out_en_port,
  input  logic              fc_req,
  input  logic              res_valid,
  input  logic [3:0]        res_data,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [7:0]        wr_addr,
  output logic [15:0]       wr_data,
  output logic              map_done,
  output logic              proto_err
);

  localparam logic [7:0] CW_LAST  = 8'(N_CONV_W - 1);
  localparam logic [7:0] MAP_LAST = 8'(N_MAP - 1);
  localparam logic [2:0] K_LAST   = 3'(FC_GRP_LEN - 1);
  localparam logic [3:0] GRP_LAST = 4'(N_FC_GRP - 1);

  state_t      state, state_nx;
  logic        ready_q, ready_nx;
  logic [7:0]  cnt;     // word index within the current phase (FC runs across groups)
  logic [2:0]  k;       // word index within the current FC group
  logic [3:0]  grp;     // completed FC groups
  logic [3:0]  label;

  logic [15:0] bus, bus_rev;
  logic        accept, mode_ok, take, drop, last;
  logic [1:0]  sel_nx;

  assign bus    = {data_in_port, data_inout_i};
  assign accept = in_valid_port & ready_q;

  // Weight words are stored bit-reversed: bus[15] lands in wr_data[0].
  always_comb begin
    bus_rev = '0;
    for (int i = 0; i < 16; i++) bus_rev[i] = bus[15-i];
  end

  // Next state, phase-mode check and end-of-phase detection.
  always_comb begin
    state_nx = state;
    mode_ok  = 1'b0;
    last     = 1'b0;
    sel_nx   = SEL_CONV;
    case (state)
      S_CW: begin
        mode_ok = mode_port;
        last    = (cnt == CW_LAST);
        sel_nx  = SEL_CONV;
      end
      S_MAP: begin
        mode_ok = ~mode_port;
        last    = (cnt == MAP_LAST);
        sel_nx  = SEL_MAP;
      end
      S_FC_LOAD: begin
        mode_ok = mode_port;
        last    = (k == K_LAST);
        sel_nx  = SEL_FC;
      end
      default: begin
        mode_ok = 1'b0;
      end
    endcase

    take = accept & mode_ok;
    drop = accept & ~mode_ok;

    case (state)
      S_CW:       if (take && last) state_nx = S_MAP;
      S_MAP:      if (take && last) state_nx = S_FC_WAIT;
      S_FC_WAIT:  if (fc_req) state_nx = S_FC_LOAD;
      // The final word of a group wins over a simultaneous fc_req; the
      // request is looked at again once back in S_FC_WAIT.
      S_FC_LOAD:  if (take && last) state_nx = (grp == GRP_LAST) ? S_RES_WAIT : S_FC_WAIT;
      S_RES_WAIT: if (res_valid) state_nx = S_RES_OUT;
      default:    state_nx = state;
    endcase

    ready_nx = (state_nx == S_CW) || (state_nx == S_MAP) || (state_nx == S_FC_LOAD);
  end

  // State and ready registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_CW;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= ready_nx;
    end
  end

  // Phase counters: cleared at the end of conv and map, FC keeps a running address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      k   <= '0;
      grp <= '0;
    end else if (take) begin
      if (last && state != S_FC_LOAD) cnt <= '0;
      else                            cnt <= cnt + 8'd1;
      if (state == S_FC_LOAD) begin
        if (last) begin
          k   <= '0;
          grp <= grp + 4'd1;
        end else begin
          k <= k + 3'd1;
        end
      end
    end
  end

  // Registered write port, map-done pulse, sticky error and result label.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_sel    <= SEL_CONV;
      wr_addr   <= '0;
      wr_data   <= '0;
      map_done  <= 1'b0;
      proto_err <= 1'b0;
      label     <= '0;
    end else begin
      wr_en    <= take;
      map_done <= take & last & (state == S_MAP);
      if (take) begin
        wr_sel  <= sel_nx;
        wr_addr <= cnt;
        wr_data <= (state == S_MAP) ? bus : bus_rev;
      end
      if (drop || (res_valid && state != S_RES_WAIT)) proto_err <= 1'b1;
      if (state == S_RES_WAIT && res_valid) label <= res_data;
    end
  end

  assign in_ready_port = ready_q;
  assign out_en_port   = (state == S_RES_OUT);
  assign data_inout_oe = (state == S_RES_OUT);
  assign data_inout_o  = (state == S_RES_OUT) ? label : '0;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: full conv/map/FC/result sequence, protocol
// error cases and a mid-map reset followed by a fresh sequence.
module tb_io_port_ctrl;
  import io_port_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fc_req;
  logic       res_valid;
  logic [3:0] res_data;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_addr;
  logic [15:0] wr_data;
  logic       map_done;
  logic       proto_err;

  io_port_ctrl_if hif ();

  int checks   = 0;
  int failures = 0;

  // Expected writes: {wr_sel, wr_addr, wr_data}.
  logic [25:0] exp_q[$];

  logic [15:0] cw_tab[6];

  io_port_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode_port     (hif.mode_port),
    .in_valid_port (hif.in_valid_port),
    .data_in_port  (hif.data_in_port),
    .data_inout_i  (hif.data_inout_i),
    .data_inout_o  (hif.data_inout_o),
    .data_inout_oe (hif.data_inout_oe),
    .in_ready_port (hif.in_ready_port),
    .out_en_port   (hif.out_en_port),
    .fc_req        (fc_req),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .map_done      (map_done),
    .proto_err     (proto_err)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = d[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic mode, input logic [15:0] d);
    hif.in_valid_port = 1'b1;
    hif.mode_port     = mode;
    hif.data_in_port  = d[15:4];
    hif.data_inout_i  = d[3:0];
  endtask

  task automatic idle_host();
    hif.in_valid_port = 1'b0;
    hif.mode_port     = 1'b0;
    hif.data_in_port  = '0;
    hif.data_inout_i  = '0;
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_in_ready"}, 32'(hif.in_ready_port), 32'(0));
    check({phase, "_out_en"},   32'(hif.out_en_port),   32'(0));
    check({phase, "_oe"},       32'(hif.data_inout_oe), 32'(0));
    check({phase, "_pad_o"},    32'(hif.data_inout_o),  32'(0));
    check({phase, "_wr_en"},    32'(wr_en),             32'(0));
    check({phase, "_wr_sel"},   32'(wr_sel),            32'(0));
    check({phase, "_wr_addr"},  32'(wr_addr),           32'(0));
    check({phase, "_wr_data"},  32'(wr_data),           32'(0));
    check({phase, "_map_done"}, 32'(map_done),          32'(0));
    check({phase, "_proto_err"},32'(proto_err),         32'(0));
  endtask

  task automatic send_conv();
    for (int i = 0; i < 6; i++) begin
      drive_word(1'b1, cw_tab[i]);
      exp_q.push_back({SEL_CONV, 8'(i), rev16(cw_tab[i])});
      tick();
      if (i == 0) begin
        check("conv0_wr_en",   32'(wr_en),   32'(1));
        check("conv0_wr_addr", 32'(wr_addr), 32'(0));
        check("conv0_wr_data", 32'(wr_data), 32'h8000);
      end
    end
  endtask

  task automatic send_map(input int n);
    for (int i = 0; i < n; i++) begin
      drive_word(1'b0, 16'(i));
      exp_q.push_back({SEL_MAP, 8'(i), 16'(i)});
      tick();
      if (i == 134) check("map134_map_done", 32'(map_done), 32'(0));
      if (i == 135) begin
        check("map135_map_done", 32'(map_done),          32'(1));
        check("map135_wr_addr",  32'(wr_addr),           32'(135));
        check("map135_wr_data",  32'(wr_data),           32'(135));
        check("map_end_ready",   32'(hif.in_ready_port), 32'(0));
      end
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        logic [25:0] e;
        e = exp_q.pop_front();
        check("wr_word", 32'({wr_sel, wr_addr, wr_data}), 32'(e));
      end
    end
  end

  initial begin
    cw_tab = '{16'h0001, 16'h00F0, 16'h1234, 16'hA5C3, 16'hFFFE, 16'h8001};
    rst_n     = 1'b0;
    fc_req    = 1'b0;
    res_valid = 1'b0;
    res_data  = 4'd0;
    idle_host();

    // Reset state.
    tick();
    tick();
    check_reset_outputs("rst1");

    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(hif.in_ready_port), 32'(1));

    // Wrong-mode word during conv phase is dropped and flagged.
    drive_word(1'b0, 16'h5555);
    tick();
    check("bad_mode_wr_en",  32'(wr_en),     32'(0));
    check("bad_mode_err",    32'(proto_err), 32'(1));

    // Conv weights, then the full map.
    send_conv();
    send_map(136);
    idle_host();

    // Ten FC groups; valid stays high one cycle past the group's last word.
    for (int g = 0; g < 10; g++) begin
      fc_req = 1'b1;
      tick();
      fc_req = 1'b0;
      check("fc_ready_rise", 32'(hif.in_ready_port), 32'(1));
      for (int kk = 0; kk < 7; kk++) begin
        logic [15:0] d;
        d = 16'hC000 | 16'(g << 4) | 16'(kk);
        drive_word(1'b1, d);
        if (kk < 6) exp_q.push_back({SEL_FC, 8'(g * 6 + kk), rev16(d)});
        if (g == 3 && kk == 5) fc_req = 1'b1;
        tick();
        fc_req = 1'b0;
        if (kk == 5) begin
          check("fc_last_addr",  32'(wr_addr),           32'(g * 6 + 5));
          check("fc_last_ready", 32'(hif.in_ready_port), 32'(0));
        end
        if (kk == 6) check("fc_extra_no_wr", 32'(wr_en), 32'(0));
      end
      idle_host();
    end
    check("res_wait_ready", 32'(hif.in_ready_port), 32'(0));
    check("fc_all_written", 32'(exp_q.size()),      32'(0));

    // Result: label 7 appears on the pad the cycle after res_valid and sticks.
    res_data  = 4'd7;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    res_data  = 4'd0;
    check("res_out_en", 32'(hif.out_en_port),   32'(1));
    check("res_oe",     32'(hif.data_inout_oe), 32'(1));
    check("res_pad_o",  32'(hif.data_inout_o),  32'(7));
    for (int c = 1; c <= 50; c++) begin
      if (c == 20) begin
        res_data  = 4'd3;
        res_valid = 1'b1;
      end
      tick();
      res_valid = 1'b0;
      if (c % 10 == 0) begin
        check("res_hold_en", 32'(hif.out_en_port),  32'(1));
        check("res_hold_o",  32'(hif.data_inout_o), 32'(7));
      end
    end

    // Reset clears everything, including the held result.
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst2");
    rst_n = 1'b1;
    tick();
    check("ready_after_rst2", 32'(hif.in_ready_port), 32'(1));

    // res_valid outside the result-wait phase is an error and has no effect.
    res_data  = 4'd5;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("early_res_err",    32'(proto_err),       32'(1));
    check("early_res_out_en", 32'(hif.out_en_port), 32'(0));

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Abort in the middle of the map: word 70 coincides with reset.
    send_conv();
    send_map(70);
    drive_word(1'b0, 16'd70);
    rst_n = 1'b0;
    tick();
    check("abort_no_wr",  32'(wr_en),             32'(0));
    check("abort_ready",  32'(hif.in_ready_port), 32'(0));
    idle_host();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_ready_back", 32'(hif.in_ready_port), 32'(1));
    check("abort_wr_addr",    32'(wr_addr),           32'(0));
    check("abort_err_clear",  32'(proto_err),         32'(0));

    // Full resequence restarts at conv address 0.
    send_conv();
    send_map(136);
    idle_host();
    tick();
    check("reseq_fc_wait_ready", 32'(hif.in_ready_port), 32'(0));
    check("reseq_all_written",   32'(exp_q.size()),      32'(0));
    check("reseq_no_err",        32'(proto_err),         32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
